i2c_target_registers: RTL and testbench

- I2C target (responder) with 7-bit address and a byte-wide register window behind an 8-bit register pointer.
- Supports the same transaction shapes the I2CMaster issues: `[S][addr+W][reg][data]...[P]` and the combined read `[S][addr+W][reg][Sr][addr+R][data]...[P]`.
- Sits on board-level/bridge I2C buses so on-FPGA status and control registers can be reached by an external host.
- Open-drain style pins: an output of 0 pulls the line low, 1 releases it.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_line_conditioner.sv | 63 ++++++
 rtl/i2c_target_registers.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_target_registers.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and ACK levels.
package i2c_pkg;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StAddress    = 3'd1;
  localparam logic [2:0] StAddressAck = 3'd2;
  localparam logic [2:0] StPointer    = 3'd3;
  localparam logic [2:0] StWriteData  = 3'd4;
  localparam logic [2:0] StReadData   = 3'd5;
  localparam logic [2:0] StReadAck    = 3'd6;
  localparam logic [2:0] StIgnore     = 3'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_conditioner.sv
// Conditions one raw I2C pin: 2-flop synchronizer, optional glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN), and a delayed copy for edge detection.
module i2c_line_conditioner #(
  parameter int unsigned FILTER_LENGTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line_input,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_first_q;
  logic sync_second_q;
  logic previous_q;
  logic filtered;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_first_q  <= 1'b1;
      sync_second_q <= 1'b1;
      previous_q    <= 1'b1;
    end else begin
      sync_first_q  <= line_input;
      sync_second_q <= sync_first_q;
      previous_q    <= filtered;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int unsigned CountWidth = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;

  logic [CountWidth-1:0] count_q;
  logic                  filter_q;

  // The filtered value follows only after FILTER_LENGTH consecutive differing samples.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      filter_q <= 1'b1;
      count_q  <= '0;
    end else if (sync_second_q == filter_q) begin
      count_q <= '0;
    end else if (count_q == CountWidth'(FILTER_LENGTH - 1)) begin
      filter_q <= sync_second_q;
      count_q  <= '0;
    end else begin
      count_q <= count_q + CountWidth'(1);
    end
  end

  assign filtered = filter_q;
`else
  logic unused_filter_length;
  assign unused_filter_length = ^FILTER_LENGTH;
  assign filtered = sync_second_q;
`endif

  assign level = filtered;
  assign rise  = filtered & ~previous_q;
  assign fall  = ~filtered & previous_q;

endmodule

// File: rtl/i2c_target_registers.sv
// I2C target exposing a byte-wide register window behind an 8-bit pointer.
// Optional input glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_registers
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDRESS        = 7'h50,
  parameter int unsigned REGISTER_COUNT = 24,
  parameter int unsigned FILTER_LENGTH  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       scl_input,
  output logic       scl_output,
  input  logic       sda_input,
  output logic       sda_output,
  output logic [7:0] register_address,
  output logic       register_write,
  output logic [7:0] register_write_data,
  output logic       register_read,
  input  logic [7:0] register_read_data,
  output logic       busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_conditioner #(.FILTER_LENGTH(FILTER_LENGTH)) u_scl (
    .clock      (clock),
    .reset_n    (reset_n),
    .line_input (scl_input),
    .level      (scl_level),
    .rise       (scl_rise),
    .fall       (scl_fall)
  );

  i2c_line_conditioner #(.FILTER_LENGTH(FILTER_LENGTH)) u_sda (
    .clock      (clock),
    .reset_n    (reset_n),
    .line_input (sda_input),
    .level      (sda_level),
    .rise       (sda_rise),
    .fall       (sda_fall)
  );

  logic [2:0] state_q, state_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] address_q, address_d;
  logic [7:0] write_data_q, write_data_d;
  logic       rw_q, rw_d;
  logic       byte_done_q, byte_done_d;
  logic       ack_phase_q, ack_phase_d;
  logic       sda_out_q, sda_out_d;
  logic       busy_q, busy_d;
  logic       write_q, write_d;
  logic       read_q, read_d;
  logic       bus_start, bus_stop, in_range;

  assign bus_start = scl_level & sda_fall;
  assign bus_stop  = scl_level & sda_rise;
  assign in_range  = 32'(address_q) < REGISTER_COUNT;

  always_comb begin
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    shift_d      = shift_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    rw_d         = rw_q;
    byte_done_d  = byte_done_q;
    ack_phase_d  = ack_phase_q;
    sda_out_d    = sda_out_q;
    busy_d       = busy_q;
    write_d      = 1'b0;
    read_d       = 1'b0;
    if (bus_start) begin
      state_d     = StAddress;
      bit_count_d = '0;
      byte_done_d = 1'b0;
      ack_phase_d = 1'b0;
      sda_out_d   = 1'b1;
      busy_d      = 1'b1;
    end else if (bus_stop) begin
      state_d     = StIdle;
      bit_count_d = '0;
      byte_done_d = 1'b0;
      ack_phase_d = 1'b0;
      sda_out_d   = 1'b1;
      busy_d      = 1'b0;
    end else begin
      // User read data is captured on the strobe cycle, one clock after the SCL fall.
      if (read_q) begin
        shift_d   = register_read_data;
        sda_out_d = register_read_data[7];
      end
      case (state_q)
        StAddress: begin
          if (scl_rise) begin
            shift_d     = {shift_q[6:0], sda_level};
            bit_count_d = bit_count_q + 4'd1;
            if (bit_count_q == 4'd7) begin
              ack_phase_d = 1'b0;
              if (shift_q[6:0] == ADDRESS) begin
                state_d = StAddressAck;
                rw_d    = sda_level;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddressAck: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_out_d   = I2C_ACK;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              byte_done_d = 1'b0;
              bit_count_d = '0;
              sda_out_d   = 1'b1;
              if (!rw_q) begin
                state_d = StPointer;
              end else begin
                state_d = StReadData;
                read_d  = in_range;
                shift_d = 8'hFF;
              end
            end
          end
        end
        StPointer, StWriteData: begin
          if (scl_rise && !byte_done_q) begin
            shift_d     = {shift_q[6:0], sda_level};
            bit_count_d = bit_count_q + 4'd1;
            if (bit_count_q == 4'd7) begin
              byte_done_d = 1'b1;
              if (state_q == StPointer) address_d = {shift_q[6:0], sda_level};
            end
          end
          if (scl_fall && byte_done_q) begin
            if (!ack_phase_q) begin
              sda_out_d   = I2C_ACK;
              ack_phase_d = 1'b1;
              if (state_q == StWriteData) begin
                write_d      = in_range;
                write_data_d = shift_q;
              end
            end else begin
              sda_out_d   = 1'b1;
              ack_phase_d = 1'b0;
              byte_done_d = 1'b0;
              bit_count_d = '0;
              state_d     = StWriteData;
              if (state_q == StWriteData) address_d = address_q + 8'd1;
            end
          end
        end
        StReadData: begin
          if (scl_rise) bit_count_d = bit_count_q + 4'd1;
          if (scl_fall) begin
            if (bit_count_q == 4'd8) begin
              sda_out_d   = 1'b1;
              ack_phase_d = 1'b0;
              state_d     = StReadAck;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_out_d = shift_q[6];
            end
          end
        end
        StReadAck: begin
          if (scl_rise && !ack_phase_q) begin
            if (sda_level == I2C_NACK) begin
              state_d = StIgnore;
            end else begin
              address_d   = address_q + 8'd1;
              ack_phase_d = 1'b1;
            end
          end
          if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            bit_count_d = '0;
            state_d     = StReadData;
            read_d      = in_range;
            shift_d     = 8'hFF;
            sda_out_d   = 1'b1;
          end
        end
        StIdle, StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bit_count_q  <= '0;
      shift_q      <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      rw_q         <= 1'b0;
      byte_done_q  <= 1'b0;
      ack_phase_q  <= 1'b0;
      sda_out_q    <= 1'b1;
      busy_q       <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      shift_q      <= shift_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      rw_q         <= rw_d;
      byte_done_q  <= byte_done_d;
      ack_phase_q  <= ack_phase_d;
      sda_out_q    <= sda_out_d;
      busy_q       <= busy_d;
      write_q      <= write_d;
      read_q       <= read_d;
    end
  end

  assign scl_output          = 1'b1;
  assign sda_output          = sda_out_q;
  assign register_address    = address_q;
  assign register_write      = write_q;
  assign register_write_data = write_data_q;
  assign register_read       = read_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_i2c_target_registers.sv
`timescale 1ns/1ps
// Bench for i2c_target_registers: bit-banged host, register-pointer reference model,
// and a strobe scoreboard drained by an independent monitor.
module tb_i2c_target_registers;

  localparam int Q        = 10;  // quarter SCL period in clocks
  localparam int RegCount = 24;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       scl_line, sda_line;
  logic       scl_output, sda_output;
  logic [7:0] register_address, register_write_data, register_read_data;
  logic       register_write, register_read, busy;

  assign scl_line           = host_scl & scl_output;
  assign sda_line           = host_sda & sda_output;
  assign register_read_data = 8'h40 + register_address;

  i2c_target_registers dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .scl_input           (scl_line),
    .scl_output          (scl_output),
    .sda_input           (sda_line),
    .sda_output          (sda_output),
    .register_address    (register_address),
    .register_write      (register_write),
    .register_write_data (register_write_data),
    .register_read       (register_read),
    .register_read_data  (register_read_data),
    .busy                (busy)
  );

  always #10 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          sda_low_count = 0;
  logic [15:0] exp_w[$];
  logic [7:0]  exp_r[$];
  logic [7:0]  mptr = 8'h00;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the expected strobe whenever the DUT presents one.
  always @(negedge clock) begin
    if (reset_n) begin
      if (!sda_output) sda_low_count++;
      if (register_write || register_read)
        check("strobe_exclusive", 32'(register_write & register_read), 0);
      if (register_write) begin
        if (exp_w.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no strobe",
                   register_address, register_write_data);
        end else begin
          check("write_strobe", {16'h0, register_address, register_write_data}, 32'(exp_w.pop_front()));
        end
      end
      if (register_read) begin
        if (exp_r.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read: got addr 0x%0h, expected no strobe", register_address);
        end else begin
          check("read_strobe", 32'(register_address), 32'(exp_r.pop_front()));
        end
      end
    end
  end

  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_start();
    host_sda = 1'b1; wait_clocks(Q);
    host_scl = 1'b1; wait_clocks(Q);
    host_sda = 1'b0; wait_clocks(Q);
    host_scl = 1'b0; wait_clocks(Q);
  endtask

  task automatic bus_stop();
    host_sda = 1'b0; wait_clocks(Q);
    host_scl = 1'b1; wait_clocks(Q);
    host_sda = 1'b1; wait_clocks(Q);
  endtask

  task automatic write_bit(input logic b);
    host_sda = b;    wait_clocks(Q);
    host_scl = 1'b1; wait_clocks(2 * Q);
    host_scl = 1'b0; wait_clocks(Q);
  endtask

  task automatic read_bit(output logic b);
    host_sda = 1'b1; wait_clocks(Q);
    host_scl = 1'b1; wait_clocks(Q);
    b = sda_line;    wait_clocks(Q);
    host_scl = 1'b0; wait_clocks(Q);
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] data);
    logic b;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      data = {data[6:0], b};
    end
    write_bit(ack);
  endtask

  task automatic end_checks(input string what);
    wait_clocks(Q);
    check({what, "_busy_after_stop"}, 32'(busy), 0);
    check({what, "_pointer"}, 32'(register_address), 32'(mptr));
  endtask

  // Write transaction: addressing rules decide the ACKs; model pointer decides strobes.
  task automatic write_tx(input logic [6:0] addr7, input logic [7:0] ptr, input int n,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic       ack, match;
    logic [7:0] data[3];
    logic [7:0] p;
    data  = '{d0, d1, d2};
    match = (addr7 == 7'h50);
    p     = ptr;
    if (match) begin
      for (int i = 0; i < n; i++) begin
        if (int'(p) < RegCount) exp_w.push_back({p, data[i]});
        p = p + 8'd1;
      end
    end
    bus_start();
    check("busy_after_start", 32'(busy), 1);
    write_byte({addr7, 1'b0}, ack);
    check("w_addr_ack", 32'(ack), 32'(!match));
    write_byte(ptr, ack);
    check("w_pointer_ack", 32'(ack), 32'(!match));
    for (int i = 0; i < n; i++) begin
      write_byte(data[i], ack);
      check("w_data_ack", 32'(ack), 32'(!match));
    end
    bus_stop();
    if (match) mptr = p;
    end_checks("write");
  endtask

  // Combined read: host ACKs every byte but the last.
  task automatic read_tx(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] p, got;
    logic [7:0] exp_b[3];
    p = ptr;
    for (int i = 0; i < n; i++) begin
      if (int'(p) < RegCount) begin
        exp_r.push_back(p);
        exp_b[i] = 8'h40 + p;
      end else begin
        exp_b[i] = 8'hFF;
      end
      if (i < n - 1) p = p + 8'd1;
    end
    bus_start();
    write_byte(8'hA0, ack);
    check("r_addr_w_ack", 32'(ack), 0);
    write_byte(ptr, ack);
    check("r_pointer_ack", 32'(ack), 0);
    bus_start();
    write_byte(8'hA1, ack);
    check("r_addr_r_ack", 32'(ack), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, got);
      check("read_byte", 32'(got), 32'(exp_b[i]));
    end
    check("sda_released_after_nack", 32'(sda_output), 1);
    bus_stop();
    mptr = p;
    end_checks("read");
  endtask

  task automatic glitch_test();
    logic seen;
    seen = 1'b0;
    host_sda = 1'b0; wait_clocks(2);
    host_sda = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_clocks(1);
      seen = seen | busy;
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("glitch_start_seen", 32'(seen), 0);
`else
    check("glitch_start_seen", 32'(seen), 1);
`endif
    wait_clocks(Q);
  endtask

  task automatic random_phase();
    logic [7:0] ptr;
    int         kind, n;
    for (int it = 0; it < 12; it++) begin
      ptr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(0, RegCount - 1));
      n    = int'($urandom_range(1, 3));
      kind = int'($urandom_range(0, 4));
      if (kind == 0)
        write_tx(7'h51, ptr, n, 8'($urandom), 8'($urandom), 8'($urandom));
      else if (kind <= 2)
        write_tx(7'h50, ptr, n, 8'($urandom), 8'($urandom), 8'($urandom));
      else
        read_tx(ptr, n);
    end
  endtask

  initial begin
    int         low_before;
    logic       ack;
    wait_clocks(4);
    check("reset_sda", 32'(sda_output), 1);
    check("reset_scl", 32'(scl_output), 1);
    check("reset_strobes", {30'h0, register_write, register_read}, 0);
    check("reset_pointer", 32'(register_address), 0);
    check("reset_write_data", 32'(register_write_data), 0);
    check("reset_busy", 32'(busy), 0);
    reset_n = 1'b1;
    wait_clocks(Q);

    write_tx(7'h50, 8'h05, 2, 8'h11, 8'h22, 8'h00);
    read_tx(8'h03, 2);

    low_before = sda_low_count;
    write_tx(7'h58, 8'h01, 0, 8'h00, 8'h00, 8'h00);
    check("wrong_addr_sda_never_low", 32'(sda_low_count), 32'(low_before));

    write_tx(7'h50, 8'h20, 1, 8'h55, 8'h00, 8'h00);
    read_tx(8'h20, 1);
    write_tx(7'h50, 8'hFF, 2, 8'h12, 8'h34, 8'h00);

    // Abort a write after four data bits.
    bus_start();
    write_byte(8'hA0, ack);
    check("abort_addr_ack", 32'(ack), 0);
    write_byte(8'h07, ack);
    check("abort_pointer_ack", 32'(ack), 0);
    mptr = 8'h07;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    end_checks("abort");
    write_tx(7'h50, 8'h02, 1, 8'h99, 8'h00, 8'h00);

    // Reset while the target drives the first read bit (0x43 has MSB 0).
    exp_r.push_back(8'h03);
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    bus_start();
    write_byte(8'hA1, ack);
    check("mid_read_ack", 32'(ack), 0);
    check("mid_read_driving_low", 32'(sda_output), 0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("reset_releases_sda", 32'(sda_output), 1);
    wait_clocks(3);
    reset_n = 1'b1;
    bus_stop();
    mptr = 8'h00;
    end_checks("after_reset");

    glitch_test();
    random_phase();

    wait_clocks(20);
    check("writes_outstanding", 32'(exp_w.size()), 0);
    check("reads_outstanding", 32'(exp_r.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog: run still active at time limit, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit reached");
  end

endmodule
